// File: rtl/knight_pkg.sv
// Shared constants and types for the knight's-tour motion sequencer.
package knight_pkg;

   localparam int NUM_MOVES = 24;

   // Command opcodes, field [15:12]
   localparam logic [3:0] MOVE         = 4'b0010;
   localparam logic [3:0] MOVE_FANFARE = 4'b0011;

   // Headings, field [11:4]
   localparam logic [7:0] NORTH = 8'h00;
   localparam logic [7:0] WEST  = 8'h3F;
   localparam logic [7:0] SOUTH = 8'h7F;
   localparam logic [7:0] EAST  = 8'hBF;

   typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

   function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [7:0] hd,
                                          input logic [3:0] sq);
      return {op, hd, sq};
   endfunction

endpackage

// File: rtl/move_decoder.sv
// Splits a one-hot knight move into a vertical move and a horizontal
// move-with-fanfare command. Lowest set bit wins; an empty move yields
// zero-square commands with heading 00.
module move_decoder
   import knight_pkg::*;
(
   input  logic [7:0]  move,
   output logic [15:0] vert_cmd,
   output logic [15:0] horz_cmd
);

   logic signed [3:0] dx, dy;
   logic [3:0]        adx, ady;
   logic [7:0]        v_hd, h_hd;

   // Displacement of the lowest set move bit (+x east, +y north)
   always_comb begin
      dx = 4'sd0;
      dy = 4'sd0;
      casez (move)
         8'b???????1: begin dx =  4'sd1; dy =  4'sd2; end
         8'b??????10: begin dx = -4'sd1; dy =  4'sd2; end
         8'b?????100: begin dx = -4'sd2; dy =  4'sd1; end
         8'b????1000: begin dx = -4'sd2; dy = -4'sd1; end
         8'b???10000: begin dx = -4'sd1; dy = -4'sd2; end
         8'b??100000: begin dx =  4'sd1; dy = -4'sd2; end
         8'b?1000000: begin dx =  4'sd2; dy = -4'sd1; end
         8'b10000000: begin dx =  4'sd2; dy =  4'sd1; end
         default:     begin dx =  4'sd0; dy =  4'sd0; end
      endcase
   end

   // Heading and magnitude; zero displacement keeps heading 00
   always_comb begin
      ady  = (dy < 0) ? 4'(-dy) : 4'(dy);
      adx  = (dx < 0) ? 4'(-dx) : 4'(dx);
      v_hd = (dy < 0) ? SOUTH : NORTH;
      h_hd = (dx < 0) ? WEST : ((dx > 0) ? EAST : NORTH);
      vert_cmd = mk_cmd(MOVE, v_hd, ady);
      horz_cmd = mk_cmd(MOVE_FANFARE, h_hd, adx);
   end

endmodule

// File: rtl/tour_sequencer.sv
// Walks the solved tour one move at a time, issuing a vertical then a
// horizontal command per move over the command-processor handshake. Outside
// a tour the UART command path is muxed straight through.
module tour_sequencer
   import knight_pkg::*;
#(
   parameter logic [7:0] POS_ACK = 8'hA5,
   parameter logic [7:0] INT_ACK = 8'h5A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

   state_t      state;
   logic        rdy_q;    // tour-side cmd_rdy, set on VERT/HORZ entry
   logic        last_q;   // in WAIT_H of the final move
   logic [15:0] vert_cmd, horz_cmd;

   // move is read by the registered mv_indx, so the decoded command is
   // fixed for the whole time the state machine sits on one index
   move_decoder u_dec (
      .move     (move),
      .vert_cmd (vert_cmd),
      .horz_cmd (horz_cmd)
   );

   // Tour state machine with registered handshake flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mv_indx <= '0;
         rdy_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_tour) begin
               mv_indx <= '0;
               rdy_q   <= 1'b1;
               state   <= VERT;
            end
            VERT: if (clr_cmd_rdy) begin
               rdy_q <= 1'b0;
               state <= WAIT_V;
            end
            WAIT_V: if (send_resp) begin
               rdy_q <= 1'b1;
               state <= HORZ;
            end
            HORZ: if (clr_cmd_rdy) begin
               rdy_q  <= 1'b0;
               last_q <= (mv_indx == LAST_IDX);
               state  <= WAIT_H;
            end
            WAIT_H: if (send_resp) begin
               last_q <= 1'b0;
               if (last_q) begin
                  mv_indx <= '0;
                  rdy_q   <= 1'b0;
                  state   <= IDLE;
               end else begin
                  mv_indx <= mv_indx + 5'd1;
                  rdy_q   <= 1'b1;
                  state   <= VERT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output mux: UART pass-through in IDLE, tour commands otherwise
   always_comb begin
      if (state == IDLE) begin
         cmd              = cmd_UART;
         cmd_rdy          = cmd_rdy_UART;
         clr_cmd_rdy_UART = clr_cmd_rdy;
         resp             = POS_ACK;
      end else begin
         cmd              = (state == VERT || state == WAIT_V) ? vert_cmd : horz_cmd;
         cmd_rdy          = rdy_q;
         clr_cmd_rdy_UART = 1'b0;
         resp             = last_q ? POS_ACK : INT_ACK;
      end
   end

endmodule

// File: tb/tb_tour_sequencer.sv
// Directed bench for tour_sequencer: pass-through, single-move decode,
// full 24-move tour with a model command processor, and reset abort.
module tb_tour_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   int vectors = 0;
   int miscompares = 0;

   logic        use_table;
   logic [7:0]  fixed_move;
   logic [7:0]  tour [0:23];

   always #5 clk = ~clk;

   assign move = use_table ? tour[mv_indx] : fixed_move;

   tour_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .send_resp        (send_resp),
      .resp             (resp)
   );

   // Hand-derived expected commands, lowest set bit first
   function automatic logic [15:0] exp_v(input logic [7:0] m);
      casez (m)
         8'b???????1: return 16'h2002;
         8'b??????10: return 16'h2002;
         8'b?????100: return 16'h2001;
         8'b????1000: return 16'h27F1;
         8'b???10000: return 16'h27F2;
         8'b??100000: return 16'h27F2;
         8'b?1000000: return 16'h27F1;
         8'b10000000: return 16'h2001;
         default:     return 16'h2000;
      endcase
   endfunction

   function automatic logic [15:0] exp_h(input logic [7:0] m);
      casez (m)
         8'b???????1: return 16'h3BF1;
         8'b??????10: return 16'h33F1;
         8'b?????100: return 16'h33F2;
         8'b????1000: return 16'h33F2;
         8'b???10000: return 16'h33F1;
         8'b??100000: return 16'h3BF1;
         8'b?1000000: return 16'h3BF2;
         8'b10000000: return 16'h3BF2;
         default:     return 16'h3000;
      endcase
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start_tour = 0; clr_cmd_rdy = 0; send_resp = 0;
      cmd_rdy_UART = 0; cmd_UART = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cmd_UART = 16'h2004; cmd_rdy_UART = 1'b1;
      #1;
      vectors++; if (mv_indx !== 5'd0) begin miscompares++; $display("FAIL rst_mv_indx got %h exp %h", mv_indx, 5'd0); end
      vectors++; if (cmd !== 16'h2004) begin miscompares++; $display("FAIL rst_cmd got %h exp %h", cmd, 16'h2004); end
      vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_rdy got %b exp 1", cmd_rdy); end
      vectors++; if (resp !== 8'hA5) begin miscompares++; $display("FAIL rst_resp got %h exp a5", resp); end
      @(negedge clk);
      rst_n = 1'b1;
      clr_cmd_rdy = 1'b1;
      #1;
      vectors++; if (clr_cmd_rdy_UART !== 1'b1) begin miscompares++; $display("FAIL idle_clr_uart got %b exp 1", clr_cmd_rdy_UART); end
      vectors++; if (cmd !== 16'h2004) begin miscompares++; $display("FAIL idle_cmd got %h exp 2004", cmd); end
      @(negedge clk);
      clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
      #1;
      vectors++; if (clr_cmd_rdy_UART !== 1'b0) begin miscompares++; $display("FAIL idle_clr_uart_low got %b exp 0", clr_cmd_rdy_UART); end
      vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL idle_rdy_low got %b exp 0", cmd_rdy); end
   endtask

   task automatic test_first_move();
      apply_reset();
      use_table = 0; fixed_move = 8'h01;
      @(negedge clk);
      start_tour = 1'b1;
      #1;
      vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL start_same_cycle_rdy got %b exp 0", cmd_rdy); end
      @(negedge clk);
      start_tour = 1'b0;
      #1;
      vectors++; if (cmd !== 16'h2002) begin miscompares++; $display("FAIL m01_vert got %h exp 2002", cmd); end
      vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL m01_vert_rdy got %b exp 1", cmd_rdy); end
      vectors++; if (resp !== 8'h5A) begin miscompares++; $display("FAIL m01_resp got %h exp 5a", resp); end
      // clr and send_resp together: only clr honoured
      @(negedge clk);
      clr_cmd_rdy = 1'b1; send_resp = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      #1;
      vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL m01_waitv_rdy got %b exp 0", cmd_rdy); end
      vectors++; if (cmd !== 16'h2002) begin miscompares++; $display("FAIL m01_waitv_hold got %h exp 2002", cmd); end
      @(negedge clk);
      #1;
      vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL m01_waitv_stay got %b exp 0", cmd_rdy); end
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      #1;
      vectors++; if (cmd !== 16'h3BF1) begin miscompares++; $display("FAIL m01_horz got %h exp 3bf1", cmd); end
      vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL m01_horz_rdy got %b exp 1", cmd_rdy); end
      vectors++; if (resp !== 8'h5A) begin miscompares++; $display("FAIL m01_horz_resp got %h exp 5a", resp); end
   endtask

   task automatic test_move08();
      apply_reset();
      use_table = 0; fixed_move = 8'h08;
      @(negedge clk); start_tour = 1'b1;
      @(negedge clk); start_tour = 1'b0;
      #1;
      vectors++; if (cmd !== 16'h27F1) begin miscompares++; $display("FAIL m08_vert got %h exp 27f1", cmd); end
      clr_cmd_rdy = 1'b1;
      @(negedge clk); clr_cmd_rdy = 1'b0; send_resp = 1'b1;
      @(negedge clk); send_resp = 1'b0;
      #1;
      vectors++; if (cmd !== 16'h33F2) begin miscompares++; $display("FAIL m08_horz got %h exp 33f2", cmd); end
      // empty move decodes to zero-square commands
      apply_reset();
      fixed_move = 8'h00;
      @(negedge clk); start_tour = 1'b1;
      @(negedge clk); start_tour = 1'b0;
      #1;
      vectors++; if (cmd !== 16'h2000) begin miscompares++; $display("FAIL m00_vert got %h exp 2000", cmd); end
      clr_cmd_rdy = 1'b1;
      @(negedge clk); clr_cmd_rdy = 1'b0; send_resp = 1'b1;
      @(negedge clk); send_resp = 1'b0;
      #1;
      vectors++; if (cmd !== 16'h3000) begin miscompares++; $display("FAIL m00_horz got %h exp 3000", cmd); end
   endtask

   task automatic test_full_tour();
      logic [15:0] exp_cmd;
      logic [7:0]  exp_resp;
      apply_reset();
      for (int i = 0; i < 24; i++) tour[i] = 8'h01 << (i % 8);
      tour[9]  = 8'h00;
      tour[13] = 8'h06;   // non-one-hot: bit1 wins
      tour[20] = 8'hC0;   // bit6 wins
      use_table = 1;
      @(negedge clk); start_tour = 1'b1;
      @(negedge clk); start_tour = 1'b0;
      for (int n = 0; n < 48; n++) begin
         exp_cmd = n[0] ? exp_h(tour[n/2]) : exp_v(tour[n/2]);
         #1;
         vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL tour_rdy n=%0d got %b exp 1", n, cmd_rdy); end
         vectors++; if (cmd !== exp_cmd) begin miscompares++; $display("FAIL tour_cmd n=%0d got %h exp %h", n, cmd, exp_cmd); end
         vectors++; if (mv_indx !== 5'(n/2)) begin miscompares++; $display("FAIL tour_idx n=%0d got %0d exp %0d", n, mv_indx, n/2); end
         if (n == 2) begin cmd_UART = 16'hF00D; cmd_rdy_UART = 1'b1; end
         repeat (2) @(negedge clk);
         clr_cmd_rdy = 1'b1;
         #1;
         vectors++; if (cmd !== exp_cmd) begin miscompares++; $display("FAIL tour_stable n=%0d got %h exp %h", n, cmd, exp_cmd); end
         vectors++; if (clr_cmd_rdy_UART !== 1'b0) begin miscompares++; $display("FAIL tour_clr_uart n=%0d got %b exp 0", n, clr_cmd_rdy_UART); end
         @(negedge clk);
         clr_cmd_rdy = 1'b0;
         exp_resp = (n == 47) ? 8'hA5 : 8'h5A;
         #1;
         vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL tour_wait_rdy n=%0d got %b exp 0", n, cmd_rdy); end
         vectors++; if (resp !== exp_resp) begin miscompares++; $display("FAIL tour_resp n=%0d got %h exp %h", n, resp, exp_resp); end
         if (n == 11) start_tour = 1'b1;
         @(negedge clk);
         start_tour = 1'b0;
         repeat (8) @(negedge clk);
         send_resp = 1'b1;
         @(negedge clk);
         send_resp = 1'b0;
      end
      #1;
      vectors++; if (mv_indx !== 5'd0) begin miscompares++; $display("FAIL tour_end_idx got %0d exp 0", mv_indx); end
      vectors++; if (cmd !== 16'hF00D) begin miscompares++; $display("FAIL tour_end_uart_cmd got %h exp f00d", cmd); end
      vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL tour_end_uart_rdy got %b exp 1", cmd_rdy); end
      vectors++; if (resp !== 8'hA5) begin miscompares++; $display("FAIL tour_end_resp got %h exp a5", resp); end
      clr_cmd_rdy = 1'b1;
      #1;
      vectors++; if (clr_cmd_rdy_UART !== 1'b1) begin miscompares++; $display("FAIL tour_end_clr_uart got %b exp 1", clr_cmd_rdy_UART); end
      @(negedge clk);
      clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
   endtask

   task automatic test_reset_mid_tour();
      apply_reset();
      use_table = 1;
      cmd_UART = 16'h2004;
      @(negedge clk); start_tour = 1'b1;
      @(negedge clk); start_tour = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         #1;
         vectors++; if (mv_indx !== 5'(i)) begin miscompares++; $display("FAIL abort_idx i=%0d got %0d exp %0d", i, mv_indx, i); end
         clr_cmd_rdy = 1'b1;
         @(negedge clk); clr_cmd_rdy = 1'b0; send_resp = 1'b1;
         @(negedge clk); send_resp = 1'b0; clr_cmd_rdy = 1'b1;
         @(negedge clk); clr_cmd_rdy = 1'b0;
         if (i < 10) begin
            send_resp = 1'b1;
            @(negedge clk); send_resp = 1'b0;
         end
      end
      #1;
      vectors++; if (cmd_rdy !== 1'b0 || mv_indx !== 5'd10) begin miscompares++; $display("FAIL abort_waith got rdy=%b idx=%0d exp rdy=0 idx=10", cmd_rdy, mv_indx); end
      rst_n = 1'b0;
      #1;
      vectors++; if (mv_indx !== 5'd0) begin miscompares++; $display("FAIL abort_async_idx got %0d exp 0", mv_indx); end
      vectors++; if (cmd !== 16'h2004) begin miscompares++; $display("FAIL abort_async_cmd got %h exp 2004", cmd); end
      vectors++; if (resp !== 8'hA5) begin miscompares++; $display("FAIL abort_async_resp got %h exp a5", resp); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; start_tour = 0; clr_cmd_rdy = 0; send_resp = 0;
      cmd_UART = 16'h0000; cmd_rdy_UART = 0;
      use_table = 0; fixed_move = 8'h00;
      for (int i = 0; i < 24; i++) tour[i] = 8'h01;
      test_reset();
      test_first_move();
      test_move08();
      test_full_tour();
      test_reset_mid_tour();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
